// File: rtl/npu_spi_pkg.sv
// Shared types for the SPI transaction sequencer: commands, FSM states,
// header field positions and the tile-access request entry.
package npu_spi_pkg;

    typedef enum logic [7:0] {
        CMD_NOP   = 8'h00,
        CMD_WRITE = 8'h01,
        CMD_READ  = 8'h02,
        CMD_EXEC  = 8'h03,
        CMD_CLR   = 8'h04
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_RD_GEN  = 2'd2
    } state_e;

    localparam int CMD_MSB  = 23;
    localparam int CMD_LSB  = 16;
    localparam int TI_MSB   = 15;
    localparam int TI_LSB   = 13;
    localparam int TJ_MSB   = 12;
    localparam int TJ_LSB   = 10;
    localparam int OP_MSB   = 9;
    localparam int OP_LSB   = 7;
    localparam int LEN_MSB  = 3;
    localparam int LEN_LSB  = 0;
    localparam int BYTE_MSB = 7;
    localparam int BYTE_LSB = 0;

    typedef struct packed {
        logic       we;
        logic [2:0] tile_i;
        logic [2:0] tile_j;
        logic [2:0] op;
        logic [3:0] addr;
        logic [7:0] wdata;
    } req_entry_t;

    function automatic req_entry_t make_entry(
        input logic       we,
        input logic [2:0] tile_i,
        input logic [2:0] tile_j,
        input logic [2:0] op,
        input logic [3:0] addr,
        input logic [7:0] wdata
    );
        req_entry_t e;
        e.we     = we;
        e.tile_i = tile_i;
        e.tile_j = tile_j;
        e.op     = op;
        e.addr   = addr;
        e.wdata  = wdata;
        return e;
    endfunction

endpackage

// File: rtl/spi_req_fifo.sv
// Synchronous request queue of req_entry_t; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module spi_req_fifo
    import npu_spi_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  req_entry_t push_data,
    input  logic       pop,
    output req_entry_t head,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count
);

    req_entry_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push_s, do_pop_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Turns received 24-bit SPI frames into queued tile-access requests and
// returns read data as MISO bytes.
module spi_txn_sequencer
    import npu_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        frm_valid,
    input  logic [23:0] frm_data,
    output logic        acc_req,
    input  logic        acc_gnt,
    output logic        acc_we,
    output logic [2:0]  acc_tile_i,
    output logic [2:0]  acc_tile_j,
    output logic [2:0]  acc_op,
    output logic [3:0]  acc_addr,
    output logic [7:0]  acc_wdata,
    input  logic        acc_rvalid,
    input  logic [7:0]  acc_rdata,
    output logic [7:0]  tx_byte,
    output logic        tx_load,
    output logic        busy,
    output logic        err_ovf,
    output logic        err_cmd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d, len_q, len_d;
    logic [2:0]    ti_q, ti_d, tj_q, tj_d, op_q, op_d;
    logic          err_ovf_q, err_ovf_d, err_cmd_q, err_cmd_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_load_q, tx_load_d;

    logic [7:0]    hdr_cmd_s;
    logic [2:0]    hdr_ti_s, hdr_tj_s, hdr_op_s;
    logic [3:0]    hdr_len_s;
    logic [7:0]    data_byte_s;
    logic          push_s, pop_s, can_push_s, last_beat_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    req_entry_t    push_entry_s, head_s, acc_head_s;

    assign hdr_cmd_s   = frm_data[CMD_MSB:CMD_LSB];
    assign hdr_ti_s    = frm_data[TI_MSB:TI_LSB];
    assign hdr_tj_s    = frm_data[TJ_MSB:TJ_LSB];
    assign hdr_op_s    = frm_data[OP_MSB:OP_LSB];
    assign hdr_len_s   = frm_data[LEN_MSB:LEN_LSB];
    assign data_byte_s = frm_data[BYTE_MSB:BYTE_LSB];

    assign pop_s       = acc_req && acc_gnt;
    assign can_push_s  = !fifo_full_s || pop_s;
    assign last_beat_s = (cnt_q == len_q);

    spi_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (sclk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Fields read as zero while nothing is queued so reset leaves them at 0
    assign acc_head_s = fifo_empty_s ? '0 : head_s;
    assign acc_req    = !fifo_empty_s;
    assign acc_we     = acc_head_s.we;
    assign acc_tile_i = acc_head_s.tile_i;
    assign acc_tile_j = acc_head_s.tile_j;
    assign acc_op     = acc_head_s.op;
    assign acc_addr   = acc_head_s.addr;
    assign acc_wdata  = acc_head_s.wdata;

    assign busy    = (state_q != ST_IDLE) || (fifo_count_s != '0);
    assign err_ovf = err_ovf_q;
    assign err_cmd = err_cmd_q;
    assign tx_byte = tx_byte_q;
    assign tx_load = tx_load_q;

    // FSM state register
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; cs_n high aborts any burst
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frm_valid && (hdr_cmd_s == CMD_WRITE)) begin
                    state_d = ST_WR_DATA;
                end else if (frm_valid && (hdr_cmd_s == CMD_READ)) begin
                    state_d = ST_RD_GEN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (frm_valid && can_push_s && last_beat_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_GEN: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (can_push_s && last_beat_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_GEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: queue pushes, beat counter, header latch, error flags
    always_comb begin
        push_s       = 1'b0;
        push_entry_s = '0;
        cnt_d        = cnt_q;
        len_d        = len_q;
        ti_d         = ti_q;
        tj_d         = tj_q;
        op_d         = op_q;
        err_ovf_d    = err_ovf_q;
        err_cmd_d    = err_cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (frm_valid) begin
                    case (hdr_cmd_s)
                        CMD_NOP: begin
                            cnt_d = cnt_q;
                        end
                        CMD_WRITE, CMD_READ: begin
                            ti_d  = hdr_ti_s;
                            tj_d  = hdr_tj_s;
                            op_d  = hdr_op_s;
                            len_d = hdr_len_s;
                            cnt_d = 4'd0;
                        end
                        CMD_EXEC: begin
                            push_entry_s = make_entry(1'b0, hdr_ti_s, hdr_tj_s, hdr_op_s, 4'd0, 8'd0);
                            if (can_push_s) begin
                                push_s = 1'b1;
                            end else begin
                                err_ovf_d = 1'b1;
                            end
                        end
                        CMD_CLR: begin
                            err_ovf_d = 1'b0;
                            err_cmd_d = 1'b0;
                        end
                        default: err_cmd_d = 1'b1;
                    endcase
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WR_DATA: begin
                push_entry_s = make_entry(1'b1, ti_q, tj_q, op_q, cnt_q, data_byte_s);
                if (!cs_n && frm_valid) begin
                    if (can_push_s) begin
                        push_s = 1'b1;
                        cnt_d  = last_beat_s ? cnt_q : cnt_q + 4'd1;
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RD_GEN: begin
                push_entry_s = make_entry(1'b0, ti_q, tj_q, op_q, cnt_q, 8'd0);
                if (!cs_n) begin
                    if (frm_valid) begin
                        err_cmd_d = 1'b1;
                    end else begin
                        err_cmd_d = err_cmd_q;
                    end
                    if (can_push_s) begin
                        push_s = 1'b1;
                        cnt_d  = last_beat_s ? cnt_q : cnt_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Burst context and sticky error flags
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            len_q     <= 4'd0;
            ti_q      <= 3'd0;
            tj_q      <= 3'd0;
            op_q      <= 3'd0;
            err_ovf_q <= 1'b0;
            err_cmd_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            ti_q      <= ti_d;
            tj_q      <= tj_d;
            op_q      <= op_d;
            err_ovf_q <= err_ovf_d;
            err_cmd_q <= err_cmd_d;
        end
    end

    // Read-return capture for the MISO shifter
    always_comb begin
        tx_load_d = acc_rvalid;
        if (acc_rvalid) begin
            tx_byte_d = acc_rdata;
        end else begin
            tx_byte_d = tx_byte_q;
        end
    end

    // Read-return registers
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte_q <= 8'h00;
            tx_load_q <= 1'b0;
        end else begin
            tx_byte_q <= tx_byte_d;
            tx_load_q <= tx_load_d;
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Self-checking bench for spi_txn_sequencer: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_spi_txn_sequencer;

    localparam int DEPTH = 4;

    logic        sclk = 1'b0;
    logic        rst_n, cs_n, frm_valid, acc_gnt, acc_rvalid;
    logic [23:0] frm_data;
    logic [7:0]  acc_rdata;
    logic        acc_req, acc_we, tx_load, busy, err_ovf, err_cmd;
    logic [2:0]  acc_tile_i, acc_tile_j, acc_op;
    logic [3:0]  acc_addr;
    logic [7:0]  acc_wdata, tx_byte;

    int n_checks = 0;
    int n_err    = 0;
    int n_grants = 0;
    int n_model_pops = 0;

    // reference model: queue of expected entries {we,ti,tj,op,addr,wdata}
    logic [21:0] mq[$];
    int          m_mode;   // 0 idle, 1 write burst, 2 read burst
    int          m_beat, m_len;
    logic [2:0]  m_ti, m_tj, m_op;
    logic        m_ovf, m_cmd, m_tx_load;
    logic [7:0]  m_tx_byte;

    spi_txn_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .frm_valid(frm_valid), .frm_data(frm_data),
        .acc_req(acc_req), .acc_gnt(acc_gnt), .acc_we(acc_we), .acc_tile_i(acc_tile_i),
        .acc_tile_j(acc_tile_j), .acc_op(acc_op), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata), .tx_byte(tx_byte), .tx_load(tx_load),
        .busy(busy), .err_ovf(err_ovf), .err_cmd(err_cmd)
    );

    always #5 sclk = ~sclk;

    function automatic logic [23:0] hdr(input logic [7:0] c, input logic [2:0] ti,
                                        input logic [2:0] tj, input logic [2:0] op,
                                        input logic [3:0] len);
        return {c, ti, tj, op, 3'b000, len};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_mode = 0; m_beat = 0; m_len = 0;
        m_ti = 3'd0; m_tj = 3'd0; m_op = 3'd0;
        m_ovf = 1'b0; m_cmd = 1'b0; m_tx_load = 1'b0; m_tx_byte = 8'h00;
    endfunction

    // One clock cycle: drive, compare DUT with model, advance model, wait edge
    task automatic step(input logic fv, input logic [23:0] fd, input logic csn,
                        input logic gnt, input logic rv, input logic [7:0] rd);
        logic        pop, room, exp_req;
        logic [21:0] exp_head;
        logic [11:0] exp_stat;
        frm_valid = fv; frm_data = fd; cs_n = csn; acc_gnt = gnt;
        acc_rvalid = rv; acc_rdata = rd;
        #1;
        exp_req  = (mq.size() > 0);
        exp_head = exp_req ? mq[0] : 22'd0;
        exp_stat = {(m_mode != 0) || exp_req, m_ovf, m_cmd, m_tx_load, m_tx_byte};
        n_checks++;
        if (acc_req !== exp_req) begin
            n_err++;
            $display("FAIL acc_req t=%0t got=%b exp=%b", $time, acc_req, exp_req);
        end
        n_checks++;
        if ({acc_we, acc_tile_i, acc_tile_j, acc_op, acc_addr, acc_wdata} !== exp_head) begin
            n_err++;
            $display("FAIL head t=%0t got=%h exp=%h", $time,
                     {acc_we, acc_tile_i, acc_tile_j, acc_op, acc_addr, acc_wdata}, exp_head);
        end
        n_checks++;
        if ({busy, err_ovf, err_cmd, tx_load, tx_byte} !== exp_stat) begin
            n_err++;
            $display("FAIL status{busy,ovf,cmd,load,byte} t=%0t got=%h exp=%h", $time,
                     {busy, err_ovf, err_cmd, tx_load, tx_byte}, exp_stat);
        end
        if (acc_req === 1'b1 && gnt) n_grants++;

        pop  = exp_req && gnt;
        room = (mq.size() < DEPTH) || pop;
        if (pop) begin
            void'(mq.pop_front());
            n_model_pops++;
        end
        if (m_mode != 0 && csn) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (fv) begin
                case (fd[23:16])
                    8'h00: ;
                    8'h01, 8'h02: begin
                        m_mode = (fd[23:16] == 8'h01) ? 1 : 2;
                        m_ti = fd[15:13]; m_tj = fd[12:10]; m_op = fd[9:7];
                        m_len = int'(fd[3:0]); m_beat = 0;
                    end
                    8'h03: begin
                        if (room) mq.push_back({1'b0, fd[15:13], fd[12:10], fd[9:7], 4'd0, 8'd0});
                        else m_ovf = 1'b1;
                    end
                    8'h04: begin m_ovf = 1'b0; m_cmd = 1'b0; end
                    default: m_cmd = 1'b1;
                endcase
            end
        end else if (m_mode == 1) begin
            if (fv) begin
                if (room) begin
                    mq.push_back({1'b1, m_ti, m_tj, m_op, 4'(m_beat), fd[7:0]});
                    if (m_beat == m_len) m_mode = 0;
                    else m_beat++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end else begin
            if (fv) m_cmd = 1'b1;
            if (room) begin
                mq.push_back({1'b0, m_ti, m_tj, m_op, 4'(m_beat), 8'd0});
                if (m_beat == m_len) m_mode = 0;
                else m_beat++;
            end
        end
        m_tx_load = rv;
        if (rv) m_tx_byte = rd;
        @(negedge sclk);
    endtask

    task automatic idle(input int n, input logic gnt);
        for (int i = 0; i < n; i++) step(1'b0, 24'd0, 1'b0, gnt, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs_n = 1'b0; frm_valid = 1'b0; frm_data = 24'd0;
        acc_gnt = 1'b0; acc_rvalid = 1'b0; acc_rdata = 8'h00;
        model_reset();
        @(negedge sclk); @(negedge sclk);
        n_checks++;
        if ({acc_req, acc_we, acc_tile_i, acc_tile_j, acc_op, acc_addr, acc_wdata,
             tx_byte, tx_load, busy, err_ovf, err_cmd} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_values got=%h exp=0", {acc_req, acc_we, acc_tile_i, acc_tile_j,
                     acc_op, acc_addr, acc_wdata, tx_byte, tx_load, busy, err_ovf, err_cmd});
        end
        rst_n = 1'b1;
        idle(2, 1'b1);
    endtask

    task automatic test_write_basic();
        int g0 = n_grants;
        step(1'b1, 24'h012C82, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b1, {16'h0000, 8'hA0 + 8'(i)}, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(3, 1'b1);
        n_checks++;
        if (n_grants - g0 != 3 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL write_basic grants=%0d busy=%b exp grants=3 busy=0", n_grants - g0, busy);
        end
    endtask

    task automatic test_read_stall();
        int g0 = n_grants;
        step(1'b1, hdr(8'h02, 3'd5, 3'd2, 3'd6, 4'd7), 1'b0, 1'b0, 1'b0, 8'h00);
        idle(8, 1'b0);
        n_checks++;
        if (acc_req !== 1'b1 || busy !== 1'b1 || n_grants != g0) begin
            n_err++;
            $display("FAIL read_stall req=%b busy=%b grants=%0d exp 1 1 0", acc_req, busy, n_grants - g0);
        end
        idle(12, 1'b1);
        n_checks++;
        if (n_grants - g0 != 8 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL read_drain grants=%0d busy=%b exp 8 0", n_grants - g0, busy);
        end
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 8'h5A);
        n_checks++;
        if (tx_byte !== 8'h5A || tx_load !== 1'b1) begin
            n_err++;
            $display("FAIL tx_capture byte=%h load=%b exp 5a 1", tx_byte, tx_load);
        end
        idle(1, 1'b0);
        n_checks++;
        if (tx_byte !== 8'h5A || tx_load !== 1'b0) begin
            n_err++;
            $display("FAIL tx_hold byte=%h load=%b exp 5a 0", tx_byte, tx_load);
        end
    endtask

    task automatic test_write_ovf();
        int g0 = n_grants;
        step(1'b1, hdr(8'h01, 3'd7, 3'd0, 3'd3, 4'd5), 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b1, {16'hFFFF, 8'h30 + 8'(i)}, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (err_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set got=%b exp=1", err_ovf);
        end
        step(1'b0, 24'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(6, 1'b1);
        n_checks++;
        if (n_grants - g0 != 4) begin
            n_err++;
            $display("FAIL ovf_accepted got=%0d exp=4", n_grants - g0);
        end
        step(1'b1, hdr(8'h04, 3'd0, 3'd0, 3'd0, 4'd0), 1'b0, 1'b0, 1'b0, 8'h00);
        idle(1, 1'b0);
        n_checks++;
        if (err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear got=%b exp=0", err_ovf);
        end
    endtask

    task automatic test_bad_cmd();
        step(1'b1, 24'h7F1234, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(1, 1'b1);
        n_checks++;
        if (err_cmd !== 1'b1 || acc_req !== 1'b0) begin
            n_err++;
            $display("FAIL bad_cmd err_cmd=%b acc_req=%b exp 1 0", err_cmd, acc_req);
        end
        step(1'b1, hdr(8'h04, 3'd0, 3'd0, 3'd0, 4'd0), 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, hdr(8'h02, 3'd1, 3'd1, 3'd1, 4'd1), 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 24'h0400AB, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(3, 1'b1);
        n_checks++;
        if (err_cmd !== 1'b1) begin
            n_err++;
            $display("FAIL frame_in_rdgen err_cmd=%b exp 1", err_cmd);
        end
        step(1'b1, hdr(8'h04, 3'd0, 3'd0, 3'd0, 4'd0), 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_abort();
        int g0 = n_grants;
        step(1'b1, hdr(8'h01, 3'd2, 3'd4, 3'd5, 4'd3), 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 24'h0000C3, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 24'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(3, 1'b1);
        n_checks++;
        if (n_grants - g0 != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_drain grants=%0d busy=%b exp 1 0", n_grants - g0, busy);
        end
        step(1'b1, hdr(8'h01, 3'd6, 3'd6, 3'd6, 4'd0), 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 24'h00005D, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(3, 1'b1);
        n_checks++;
        if (n_grants - g0 != 2) begin
            n_err++;
            $display("FAIL abort_next_hdr grants=%0d exp 2", n_grants - g0);
        end
    endtask

    task automatic test_len15();
        int g0 = n_grants;
        step(1'b1, hdr(8'h02, 3'd3, 3'd7, 3'd2, 4'd15), 1'b0, 1'b1, 1'b0, 8'h00);
        idle(20, 1'b1);
        n_checks++;
        if (n_grants - g0 != 16 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL len15 grants=%0d busy=%b exp 16 0", n_grants - g0, busy);
        end
    endtask

    task automatic test_random();
        int g0 = n_grants;
        int p0 = n_model_pops;
        logic [31:0] r;
        logic [23:0] fd;
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom;
            fd = r[23:0];
            if ($urandom_range(0, 9) < 7) begin
                r = 32'($urandom_range(0, 5));
                fd[23:16] = (r == 32'd5) ? 8'hFF : r[7:0];
                fd[3:0]   = 4'($urandom_range(0, 6));
            end
            r = $urandom;
            step(r[0], fd, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 4) == 0), r[15:8]);
        end
        step(1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 8'h00);
        idle(6, 1'b1);
        n_checks++;
        if (n_grants - g0 != n_model_pops - p0 || acc_req !== 1'b0) begin
            n_err++;
            $display("FAIL random_drain dut_grants=%0d model_pops=%0d acc_req=%b",
                     n_grants - g0, n_model_pops - p0, acc_req);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, hdr(8'h01, 3'd1, 3'd2, 3'd3, 4'd3), 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b1, {16'h0, 8'h90 + 8'(i)}, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 8'hE7);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({acc_req, acc_we, acc_tile_i, acc_tile_j, acc_op, acc_addr, acc_wdata,
             tx_byte, tx_load, busy, err_ovf, err_cmd} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_mid got=%h exp=0", {acc_req, acc_we, acc_tile_i, acc_tile_j,
                     acc_op, acc_addr, acc_wdata, tx_byte, tx_load, busy, err_ovf, err_cmd});
        end
        model_reset();
        @(negedge sclk);
        rst_n = 1'b1;
        idle(4, 1'b1);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_stall();
        test_write_ovf();
        test_bad_cmd();
        test_abort();
        test_len15();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
